// File: rtl/score_pkg.sv
// Shared constants and types for the score display path: value limit,
// 7-segment codes and the BCD conversion FSM states.
package score_pkg;

  localparam int unsigned SCORE_MAX = 99;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational BCD digit to 7-segment encoder. Non-decimal codes render blank.
module seg7_encoder
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Two-digit multiplexed score display: sequential double-dabble conversion of
// val_i to BCD, digit refresh counter and registered-only output decode.
module score_display
  import score_pkg::*;
#(
  parameter int unsigned BW          = 7,
  parameter int unsigned REFRESH_DIV = 1000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [BW-1:0] val_i,
  output logic [6:0]    seg_o,
  output logic [1:0]    dig_sel_o,
  output logic          busy_o,
  output logic          ovf_o
);

  localparam int unsigned CntW = $clog2(BW + 1);
  localparam int unsigned RefW = $clog2(REFRESH_DIV);

  state_e            state_q, state_d;
  logic [BW-1:0]     last_q, last_d;
  logic [BW-1:0]     sh_q, sh_d;
  logic [3:0]        t_q, t_d, o_q, o_d;
  logic [3:0]        t_adj, o_adj;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              pend_q, pend_d;
  logic [3:0]        tens_q, tens_d, ones_q, ones_d;
  logic              ovf_q, ovf_d;
  logic [RefW-1:0]   ref_q, ref_d;
  logic              dig_idx_q, dig_idx_d;
  logic [3:0]        digit;
  logic [6:0]        enc_seg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      last_q    <= '0;
      sh_q      <= '0;
      t_q       <= '0;
      o_q       <= '0;
      bit_cnt_q <= '0;
      pend_q    <= 1'b0;
      tens_q    <= '0;
      ones_q    <= '0;
      ovf_q     <= 1'b0;
      ref_q     <= '0;
      dig_idx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sh_q      <= sh_d;
      t_q       <= t_d;
      o_q       <= o_d;
      bit_cnt_q <= bit_cnt_d;
      pend_q    <= pend_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      ovf_q     <= ovf_d;
      ref_q     <= ref_d;
      dig_idx_q <= dig_idx_d;
    end
  end

  // Shift-add-3 correction applied before each shift
  assign t_adj = (t_q >= 4'd5) ? t_q + 4'd3 : t_q;
  assign o_adj = (o_q >= 4'd5) ? o_q + 4'd3 : o_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sh_d      = sh_q;
    t_d       = t_q;
    o_d       = o_q;
    bit_cnt_d = bit_cnt_q;
    pend_d    = pend_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (val_i != last_q) begin
          last_d = val_i;
          sh_d   = val_i;
          if (val_i > BW'(SCORE_MAX)) begin
            pend_d  = 1'b1;
            state_d = ST_COMMIT;
          end else begin
            pend_d    = 1'b0;
            t_d       = '0;
            o_d       = '0;
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        t_d       = {t_adj[2:0], o_adj[3]};
        o_d       = {o_adj[2:0], sh_q[BW-1]};
        sh_d      = {sh_q[BW-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CntW'(1);
        if (bit_cnt_q == CntW'(BW - 1)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // Overflow keeps the previous digits; only the dash flag changes
        if (pend_q) begin
          ovf_d = 1'b1;
        end else begin
          tens_d = t_q;
          ones_d = o_q;
          ovf_d  = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ref_d     = ref_q + RefW'(1);
    dig_idx_d = dig_idx_q;
    if (ref_q == RefW'(REFRESH_DIV - 1)) begin
      ref_d     = '0;
      dig_idx_d = ~dig_idx_q;
    end
  end

  assign digit = dig_idx_q ? tens_q : ones_q;

  seg7_encoder u_enc (
    .bcd (digit),
    .seg (enc_seg)
  );

  always_comb begin
    seg_o = enc_seg;
    if (ovf_q) begin
      seg_o = SEG_DASH;
    end else if (dig_idx_q && BLANK_LZ && (tens_q == 4'd0)) begin
      seg_o = SEG_BLANK;
    end
  end

  assign dig_sel_o = dig_idx_q ? 2'b10 : 2'b01;
  assign busy_o    = (state_q != ST_IDLE);
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: directed scenarios plus random values
// checked against a decimal display model.
module tb_score_display;

  localparam int unsigned BW          = 7;
  localparam int unsigned REFRESH_DIV = 4;

  logic          clk;
  logic          rst;
  logic [BW-1:0] val;
  logic [6:0]    seg;
  logic [1:0]    dig_sel;
  logic          busy;
  logic          ovf;

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  score_display #(
    .BW          (BW),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_LZ    (1'b1)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .val_i     (val),
    .seg_o     (seg),
    .dig_sel_o (dig_sel),
    .busy_o    (busy),
    .ovf_o     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal model of what a slot should show for a given value
  function automatic logic [6:0] exp_seg(input int v, input bit tens_slot);
    if (v > 99) return 7'h40;
    if (tens_slot) return (v / 10 == 0) ? 7'h00 : seg_tbl[v / 10];
    return seg_tbl[v % 10];
  endfunction

  // Wait until the converter has been idle for two samples in a row
  task automatic settle(input string tag);
    int zeros = 0;
    for (int i = 0; i < 40 && zeros < 2; i++) begin
      tick();
      if (!busy) zeros++;
      else zeros = 0;
    end
    chk({tag, "_settle"}, 32'(zeros >= 2), 32'd1);
  endtask

  task automatic check_disp(input int v, input string tag);
    for (int i = 0; i < 2 * REFRESH_DIV; i++) begin
      chk({tag, "_seg"}, 32'(seg), 32'(exp_seg(v, dig_sel == 2'b10)));
      chk({tag, "_ovf"}, 32'(ovf), 32'(v > 99));
      tick();
    end
  endtask

  // Digit select must stay one-hot and each slot must last REFRESH_DIV clocks
  logic [1:0] mon_prev;
  int         mon_run;
  bit         mon_first;
  always @(negedge clk) begin
    if (!mon_en) begin
      mon_prev  = dig_sel;
      mon_run   = 0;
      mon_first = 1'b1;
    end else begin
      chk("onehot", 32'($onehot(dig_sel)), 32'd1);
      if (dig_sel == mon_prev) begin
        mon_run++;
      end else begin
        if (!mon_first) chk("slot_len", 32'(mon_run), 32'(REFRESH_DIV));
        mon_first = 1'b0;
        mon_run   = 1;
        mon_prev  = dig_sel;
      end
    end
  end

  initial begin
    int v;
    rst = 1'b1;
    val = '0;
    tick();
    tick();
    chk("rst_dig_sel", 32'(dig_sel), 32'h1);
    chk("rst_seg", 32'(seg), 32'h3F);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < REFRESH_DIV; i++) tick();
    chk("rst_tens_sel", 32'(dig_sel), 32'h2);
    chk("rst_tens_seg", 32'(seg), 32'h00);

    // Conversion latency: capture edge then BW shifts and a commit
    val = BW'(42);
    for (int i = 0; i < BW + 1; i++) begin
      tick();
      chk("lat_busy_hi", 32'(busy), 32'd1);
    end
    tick();
    chk("lat_busy_lo", 32'(busy), 32'd0);
    check_disp(42, "v42");

    for (int i = 0; i <= 99; i++) begin
      val = BW'(i);
      settle("ramp");
      check_disp(i, "ramp");
    end

    // Overflow after 99, then back in range
    val = BW'(100);
    tick();
    chk("ovf_lat1", 32'(ovf), 32'd0);
    tick();
    chk("ovf_lat2", 32'(ovf), 32'd1);
    check_disp(100, "v100");
    val = BW'(127);
    settle("v127");
    check_disp(127, "v127");
    val = BW'(7);
    settle("v7");
    check_disp(7, "v7");

    // Value changes while busy: latest one must end up displayed
    val = BW'(12);
    tick();
    tick();
    val = BW'(34);
    tick();
    tick();
    val = BW'(56);
    settle("chg");
    check_disp(56, "chg56");

    // Reset mid-conversion abandons it; held value converts afresh
    val = BW'(88);
    for (int i = 0; i < 4; i++) tick();
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_dig_sel", 32'(dig_sel), 32'h1);
    chk("midrst_seg", 32'(seg), 32'h3F);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < BW + 1; i++) tick();
    chk("midrst_busy_hi", 32'(busy), 32'd1);
    tick();
    chk("midrst_busy_lo", 32'(busy), 32'd0);
    check_disp(88, "v88");

    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 127));
      val = BW'(v);
      settle("rand");
      check_disp(v, "rand");
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
